// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the ALU stack sequencer
package alu_pkg;

    localparam logic [2:0] OP_CPY  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_NEGY = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NOTY = 3'd4;
    localparam logic [2:0] OP_CPX  = 3'd5;
    localparam logic [2:0] OP_INX  = 3'd6;
    localparam logic [2:0] OP_DCX  = 3'd7;

    localparam int FLAG_SF = 0;
    localparam int FLAG_CF = 1;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_OF = 3;

    localparam logic [1:0] KIND_PUSH  = 2'd0;
    localparam logic [1:0] KIND_POP   = 2'd1;
    localparam logic [1:0] KIND_ALU   = 2'd2;
    localparam logic [1:0] KIND_CLEAR = 2'd3;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    typedef struct packed {
        logic binary;
        logic unary_x;
        logic unary_y;
    } op_class_t;

    function automatic op_class_t op_class(input logic [2:0] op);
        op_class_t c;
        c = '0;
        case (op)
            OP_ADD, OP_OR:          c.binary  = 1'b1;
            OP_CPX, OP_INX, OP_DCX: c.unary_x = 1'b1;
            default:                c.unary_y = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - operand register file with push/pop/replace and tos/nos reads
module operand_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_replace,
    input  logic                         i_clear,
    input  logic [W-1:0]                 i_wdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_depth,
    output logic [W-1:0]                 o_tos,
    output logic [W-1:0]                 o_nos
);

    localparam int SW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [SW-1:0] r_sp;
    logic [SW-1:0] w_sp_next;
    logic [AW-1:0] w_wr_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_sp == SW'(DEPTH));
    assign o_empty   = (r_sp == '0);
    assign o_depth   = r_sp;
    assign w_do_push = i_push && !o_full && !i_clear;
    assign w_do_pop  = i_pop && !o_empty && !i_clear;

    always_comb begin
        w_sp_next = r_sp;
        if (i_clear)
            w_sp_next = '0;
        else if (w_do_push)
            w_sp_next = r_sp + SW'(1);
        else if (w_do_pop)
            w_sp_next = r_sp - SW'(1);
    end

    // Replace targets the top after any pop, so a binary op folds two slots into one.
    assign w_wr_idx = AW'(w_sp_next - SW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sp <= '0;
        else
            r_sp <= w_sp_next;
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[AW'(r_sp)] <= i_wdata;
        else if (i_replace && !i_clear && (w_sp_next != '0))
            r_mem[w_wr_idx] <= i_wdata;
    end

    assign o_tos = o_empty ? '0 : r_mem[AW'(r_sp - SW'(1))];
    assign o_nos = (r_sp >= SW'(2)) ? r_mem[AW'(r_sp - SW'(2))] : '0;

endmodule

// File: rtl/alu_stack_sequencer.sv
// rtl/alu_stack_sequencer.sv - execute-stage sequencer driving a combinational ALU from an operand stack
module alu_stack_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_kind,
    input  logic [2:0]                   cmd_op,
    input  logic [W-1:0]                 cmd_imm,
    output logic [W-1:0]                 alu_x,
    output logic [W-1:0]                 alu_y,
    output logic [2:0]                   alu_op,
    input  logic [W-1:0]                 alu_z,
    input  logic [3:0]                   alu_flags,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [W-1:0]                 tos,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic [3:0]                   flags
);

    localparam int SW = $clog2(DEPTH + 1);

    state_t        r_state;
    logic [W-1:0]  r_opx;
    logic [W-1:0]  r_opy;
    logic [W-1:0]  r_res;
    logic [W-1:0]  r_alu_x;
    logic [W-1:0]  r_alu_y;
    logic [2:0]    r_op;
    logic [2:0]    r_alu_op;
    logic          r_binary;
    logic [3:0]    r_fl_cap;
    logic [3:0]    r_flags;
    logic          r_done;
    logic          r_err;
    logic [1:0]    r_err_code;

    logic          w_accept;
    op_class_t     w_cls;
    logic          w_full;
    logic          w_empty;
    logic [SW-1:0] w_depth;
    logic [W-1:0]  w_tos;
    logic [W-1:0]  w_nos;
    logic          w_push;
    logic          w_pop;
    logic          w_replace;
    logic          w_clear;
    logic [W-1:0]  w_wdata;
    logic          w_alu_short;

    assign cmd_ready   = (r_state == ST_IDLE);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_cls       = op_class(cmd_op);
    assign w_alu_short = w_cls.binary ? (w_depth < SW'(2)) : w_empty;

    assign w_push    = w_accept && (cmd_kind == KIND_PUSH);
    assign w_clear   = w_accept && (cmd_kind == KIND_CLEAR);
    assign w_pop     = (w_accept && (cmd_kind == KIND_POP)) || ((r_state == ST_WB) && r_binary);
    assign w_replace = (r_state == ST_WB);
    assign w_wdata   = w_replace ? r_res : cmd_imm;

    operand_stack #(.DEPTH(DEPTH), .W(W)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_replace (w_replace),
        .i_clear   (w_clear),
        .i_wdata   (w_wdata),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_depth   (w_depth),
        .o_tos     (w_tos),
        .o_nos     (w_nos)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_opx      <= '0;
            r_opy      <= '0;
            r_res      <= '0;
            r_alu_x    <= '0;
            r_alu_y    <= '0;
            r_op       <= OP_CPY;
            r_alu_op   <= OP_CPY;
            r_binary   <= 1'b0;
            r_fl_cap   <= '0;
            r_flags    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (cmd_kind)
                            KIND_PUSH: begin
                                r_err      <= w_full;
                                r_err_code <= w_full ? ERR_OVERFLOW : ERR_NONE;
                                r_done     <= !w_full;
                            end
                            KIND_POP: begin
                                r_err      <= w_empty;
                                r_err_code <= w_empty ? ERR_UNDERFLOW : ERR_NONE;
                                r_done     <= !w_empty;
                            end
                            KIND_CLEAR: r_done <= 1'b1;
                            default: begin
                                if (w_alu_short) begin
                                    r_err      <= 1'b1;
                                    r_err_code <= ERR_UNDERFLOW;
                                end else begin
                                    r_opx    <= w_cls.binary ? w_nos : (w_cls.unary_x ? w_tos : '0);
                                    r_opy    <= (w_cls.binary || w_cls.unary_y) ? w_tos : '0;
                                    r_op     <= cmd_op;
                                    r_binary <= w_cls.binary;
                                    r_state  <= ST_READ;
                                end
                            end
                        endcase
                    end
                end
                ST_READ: begin
                    r_alu_x  <= r_opx;
                    r_alu_y  <= r_opy;
                    r_alu_op <= r_op;
                    r_state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_res    <= alu_z;
                    r_fl_cap <= alu_flags;
                    r_done   <= 1'b1;
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    r_flags <= r_fl_cap;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_x    = r_alu_x;
    assign alu_y    = r_alu_y;
    assign alu_op   = r_alu_op;
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign tos      = w_tos;
    assign depth    = w_depth;
    assign flags    = r_flags;

endmodule

// File: tb/tb_alu_stack_sequencer.sv
// tb/tb_alu_stack_sequencer.sv - self-checking bench for alu_stack_sequencer
module tb_alu_stack_sequencer;
    import alu_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_kind = 2'd0;
    logic [2:0]    cmd_op = 3'd0;
    logic [W-1:0]  cmd_imm = '0;
    logic [W-1:0]  alu_x, alu_y, alu_z;
    logic [2:0]    alu_op;
    logic [3:0]    alu_flags;
    logic          done, err;
    logic [1:0]    err_code;
    logic [W-1:0]  tos;
    logic [3:0]    depth;
    logic [3:0]    flags;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_stack_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_z(alu_z), .alu_flags(alu_flags),
        .done(done), .err(err), .err_code(err_code), .tos(tos), .depth(depth), .flags(flags)
    );

    // Reference combinational ALU
    always_comb begin
        logic [16:0] s;
        logic [15:0] a, b;
        logic        arith;
        s = '0; a = '0; b = '0; arith = 1'b0;
        alu_z = '0;
        case (alu_op)
            OP_CPY:  alu_z = alu_y;
            OP_ADD:  begin a = alu_x; b = alu_y;    arith = 1'b1; end
            OP_NEGY: alu_z = 16'h0 - alu_y;
            OP_OR:   alu_z = alu_x | alu_y;
            OP_NOTY: alu_z = ~alu_y;
            OP_CPX:  alu_z = alu_x;
            OP_INX:  begin a = alu_x; b = 16'h0001; arith = 1'b1; end
            default: begin a = alu_x; b = 16'hFFFF; arith = 1'b1; end
        endcase
        if (arith) begin
            s     = {1'b0, a} + {1'b0, b};
            alu_z = s[15:0];
        end
        alu_flags          = '0;
        alu_flags[FLAG_SF] = alu_z[15];
        alu_flags[FLAG_ZF] = (alu_z == 16'h0);
        alu_flags[FLAG_CF] = arith && s[16];
        alu_flags[FLAG_OF] = arith && (a[15] == b[15]) && (alu_z[15] != a[15]);
    end

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  op;
        logic [15:0] imm;
        logic        ex_err;
        logic [1:0]  ex_code;
        logic [15:0] ex_tos;
        logic [3:0]  ex_depth;
        logic [3:0]  ex_flags;
        int          ex_lat;
        logic        chk_ops;
        logic [15:0] ex_ax;
        logic [15:0] ex_ay;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] k, input logic [2:0] op, input logic [15:0] imm,
                           input logic e, input logic [1:0] code, input logic [15:0] t,
                           input logic [3:0] d, input logic [3:0] fl, input int lat,
                           input logic co, input logic [15:0] ax, input logic [15:0] ay);
        vec_t v;
        v.kind = k; v.op = op; v.imm = imm; v.ex_err = e; v.ex_code = code;
        v.ex_tos = t; v.ex_depth = d; v.ex_flags = fl; v.ex_lat = lat;
        v.chk_ops = co; v.ex_ax = ax; v.ex_ay = ay;
        vecs.push_back(v);
    endtask

    task automatic do_cmd(input vec_t v);
        vec_t e;
        int   lat;
        logic got;
        logic [15:0] prev_ax, prev_ay;
        logic rdy;
        rdy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cmd_ready) begin rdy = 1'b1; break; end
        end
        chk("cmd_ready_wait", 32'(rdy), 32'd1);
        cmd_valid = 1'b1; cmd_kind = v.kind; cmd_op = v.op; cmd_imm = v.imm;
        sb.push_back(v);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        got = 1'b0; lat = 0; prev_ax = alu_x; prev_ay = alu_y;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done || err) begin lat = c; got = 1'b1; break; end
            prev_ax = alu_x; prev_ay = alu_y;
        end
        chk("response_seen", 32'(got), 32'd1);
        e = sb.pop_front();
        if (got) begin
            chk("err", 32'(err), 32'(e.ex_err));
            chk("done", 32'(done), 32'(!e.ex_err));
            if (e.ex_err) chk("err_code", 32'(err_code), 32'(e.ex_code));
            chk("latency", 32'(lat), 32'(e.ex_lat));
            if (e.chk_ops) begin
                chk("exec_alu_x", 32'(prev_ax), 32'(e.ex_ax));
                chk("exec_alu_y", 32'(prev_ay), 32'(e.ex_ay));
            end
            @(negedge clk);
            chk("pulse_one_cycle", 32'(done || err), 32'd0);
        end
        chk("tos", 32'(tos), 32'(e.ex_tos));
        chk("depth", 32'(depth), 32'(e.ex_depth));
        chk("flags", 32'(flags), 32'(e.ex_flags));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // kind, op, imm, err, code, tos, depth, flags, latency, check-ops, exec x, exec y
        add_vec(KIND_PUSH,  OP_CPY,  16'h0005, 0, 2'd0, 16'h0005, 4'd1, 4'b0000, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_PUSH,  OP_CPY,  16'h0003, 0, 2'd0, 16'h0003, 4'd2, 4'b0000, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_ALU,   OP_ADD,  16'h0000, 0, 2'd0, 16'h0008, 4'd1, 4'b0000, 3, 1, 16'h0005, 16'h0003);
        add_vec(KIND_CLEAR, OP_CPY,  16'h0000, 0, 2'd0, 16'h0000, 4'd0, 4'b0000, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_PUSH,  OP_CPY,  16'h7FFF, 0, 2'd0, 16'h7FFF, 4'd1, 4'b0000, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_PUSH,  OP_CPY,  16'h0001, 0, 2'd0, 16'h0001, 4'd2, 4'b0000, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_ALU,   OP_ADD,  16'h0000, 0, 2'd0, 16'h8000, 4'd1, 4'b1001, 3, 1, 16'h7FFF, 16'h0001);
        add_vec(KIND_CLEAR, OP_CPY,  16'h0000, 0, 2'd0, 16'h0000, 4'd0, 4'b1001, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_PUSH,  OP_CPY,  16'h0000, 0, 2'd0, 16'h0000, 4'd1, 4'b1001, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_ALU,   OP_DCX,  16'h0000, 0, 2'd0, 16'hFFFF, 4'd1, 4'b0001, 3, 1, 16'h0000, 16'h0000);
        add_vec(KIND_ALU,   OP_NOTY, 16'h0000, 0, 2'd0, 16'h0000, 4'd1, 4'b0100, 3, 1, 16'h0000, 16'hFFFF);
        add_vec(KIND_POP,   OP_CPY,  16'h0000, 0, 2'd0, 16'h0000, 4'd0, 4'b0100, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_POP,   OP_CPY,  16'h0000, 1, 2'd1, 16'h0000, 4'd0, 4'b0100, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_ALU,   OP_INX,  16'h0000, 1, 2'd1, 16'h0000, 4'd0, 4'b0100, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_PUSH,  OP_CPY,  16'h0001, 0, 2'd0, 16'h0001, 4'd1, 4'b0100, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_ALU,   OP_ADD,  16'h0000, 1, 2'd1, 16'h0001, 4'd1, 4'b0100, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_ALU,   OP_INX,  16'h0000, 0, 2'd0, 16'h0002, 4'd1, 4'b0000, 3, 1, 16'h0001, 16'h0000);
        add_vec(KIND_ALU,   OP_NEGY, 16'h0000, 0, 2'd0, 16'hFFFE, 4'd1, 4'b0001, 3, 1, 16'h0000, 16'h0002);
        add_vec(KIND_ALU,   OP_CPX,  16'h0000, 0, 2'd0, 16'hFFFE, 4'd1, 4'b0001, 3, 1, 16'hFFFE, 16'h0000);
        add_vec(KIND_PUSH,  OP_CPY,  16'h00F0, 0, 2'd0, 16'h00F0, 4'd2, 4'b0001, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_ALU,   OP_OR,   16'h0000, 0, 2'd0, 16'hFFFE, 4'd1, 4'b0001, 3, 1, 16'hFFFE, 16'h00F0);
        add_vec(KIND_ALU,   OP_CPY,  16'h0000, 0, 2'd0, 16'hFFFE, 4'd1, 4'b0001, 3, 1, 16'h0000, 16'hFFFE);
        for (int i = 0; i < 7; i++)
            add_vec(KIND_PUSH, OP_CPY, 16'h0100 + 16'(i), 0, 2'd0, 16'h0100 + 16'(i),
                    4'(i + 2), 4'b0001, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_PUSH,  OP_CPY,  16'hDEAD, 1, 2'd2, 16'h0106, 4'd8, 4'b0001, 1, 0, 16'h0, 16'h0);
        add_vec(KIND_CLEAR, OP_CPY,  16'h0000, 0, 2'd0, 16'h0000, 4'd0, 4'b0001, 1, 0, 16'h0, 16'h0);

        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_alu_x", 32'(alu_x), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_tos", 32'(tos), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);

        for (int i = 0; i < vecs.size(); i++)
            do_cmd(vecs[i]);

        // Reset asserted while an ADD is in EXEC
        begin
            vec_t v;
            v = vecs[0]; v.imm = 16'h0011; v.ex_tos = 16'h0011; v.ex_depth = 4'd1; v.ex_flags = 4'b0001;
            do_cmd(v);
            v.imm = 16'h0022; v.ex_tos = 16'h0022; v.ex_depth = 4'd2;
            do_cmd(v);
            @(negedge clk);
            cmd_valid = 1'b1; cmd_kind = KIND_ALU; cmd_op = OP_ADD;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("mid_exec_alu_x", 32'(alu_x), 32'h11);
            chk("mid_exec_alu_op", 32'(alu_op), 32'(OP_ADD));
            rst_n = 1'b0;
            #1;
            chk("async_rst_alu_x", 32'(alu_x), 32'd0);
            chk("async_rst_alu_y", 32'(alu_y), 32'd0);
            chk("async_rst_alu_op", 32'(alu_op), 32'd0);
            chk("async_rst_depth", 32'(depth), 32'd0);
            chk("async_rst_tos", 32'(tos), 32'd0);
            chk("async_rst_flags", 32'(flags), 32'd0);
            chk("async_rst_done_err", 32'({done, err, err_code}), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("post_rst_ready", 32'(cmd_ready), 32'd1);
            chk("post_rst_depth", 32'(depth), 32'd0);
            v = vecs[0]; v.kind = KIND_ALU; v.op = OP_INX; v.ex_err = 1'b1; v.ex_code = ERR_UNDERFLOW;
            v.ex_tos = 16'h0; v.ex_depth = 4'd0; v.ex_flags = 4'b0000;
            do_cmd(v);
        end

        // Back-to-back PUSHes with cmd_valid held high
        @(negedge clk);
        cmd_valid = 1'b1; cmd_kind = KIND_PUSH; cmd_imm = 16'hAAAA;
        @(posedge clk);
        #1 cmd_imm = 16'h5555;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_depth", 32'(depth), 32'd2);
        chk("b2b_tos", 32'(tos), 32'h5555);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_stack_sequencer.md
Name: alu_stack_sequencer

Overview:
- Execute-stage controller for the 16-bit ALU in the stack CPU.
- Owns a small operand stack. Accepts commands over a valid/ready handshake: push immediate, pop, ALU op, clear.
- For ALU ops it reads operands from the stack top, drives the ALU ports, captures the result and flags, and writes the result back onto the stack.
- Sits between instruction decode (command source) and a combinational ALU instance.

Parameters:
- DEPTH, 8, operand stack entries; power of two, 2..32.
- W, 16, data width; must match the ALU.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command this cycle.
- cmd_kind  in  2  0=PUSH, 1=POP, 2=ALU, 3=CLEAR.
- cmd_op  in  3  ALU opcode, used when kind=ALU: 0 CPY, 1 ADD, 2 NEGY, 3 OR, 4 NOTY, 5 CPX, 6 INX, 7 DCX.
- cmd_imm  in  W  immediate value for PUSH.
- alu_x  out  W  ALU x operand.
- alu_y  out  W  ALU y operand.
- alu_op  out  3  ALU opcode.
- alu_z  in  W  ALU result.
- alu_flags  in  4  ALU flags, bit0 SF, bit1 CF, bit2 ZF, bit3 OF.
- done  out  1  one-cycle pulse when a command completes without error.
- err  out  1  one-cycle pulse when a command is rejected.
- err_code  out  2  cause of rejection, valid with err: 1=underflow, 2=overflow.
- tos  out  W  stack[sp-1]; 0 when the stack is empty.
- depth  out  $clog2(DEPTH+1)  current entry count.
- flags  out  4  flags captured from the last completed ALU op.

Behaviour:
- Reset (asynchronous, at any time, including mid-operation):
  - state=IDLE, sp=0, flags=0, done=0, err=0, err_code=0.
  - alu_x=0, alu_y=0, alu_op=0; cmd_ready=1 once reset is released.
  - Stack contents need not be cleared.
- Handshake:
  - A command is accepted when cmd_valid & cmd_ready.
  - cmd_ready=1 only in IDLE.
  - Inputs are sampled at acceptance only.
- States: IDLE, READ, EXEC, WB.
- PUSH, POP and CLEAR complete in IDLE on the acceptance edge:
  - done or err is registered and appears the next cycle; cmd_ready stays 1, so back-to-back commands are allowed.
  - PUSH: depth==DEPTH -> err, code 2, no change. Otherwise stack[sp]=imm, sp+1.
  - POP: depth==0 -> err, code 1. Otherwise sp-1.
  - CLEAR: sp=0; flags unchanged; always done.
- ALU operand classes:
  - Binary (ADD, OR): x=NOS, y=TOS. Needs depth>=2; net depth -1.
  - Unary-y (CPY, NEGY, NOTY): x=0, y=TOS. Needs depth>=1; TOS is replaced.
  - Unary-x (CPX, INX, DCX): x=TOS, y=0. Needs depth>=1; TOS is replaced.
- ALU command, insufficient depth: err with code 1 on the next cycle; stay in IDLE; stack and flags unchanged.
- ALU command, accepted:
  - IDLE -> READ: operands registered from the stack per class.
  - READ -> EXEC: alu_x, alu_y, alu_op are driven as registered outputs, stable through EXEC.
  - EXEC -> WB: alu_z and alu_flags are captured.
  - WB: result written to the new top; sp adjusted; flags register updated; done pulses during the WB cycle; next state IDLE.
  - Total 4 cycles from acceptance to the next possible acceptance.
- Outside EXEC, alu_x, alu_y and alu_op hold their last values.
- An ALU op never overflows the stack: the result always replaces a consumed slot.
- sp wraps nowhere; bounds are always checked before any update.
- done and err are never asserted together.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants (matching the ALU's 3-bit encoding).
  - Flag bit indices.
  - cmd_kind constants.
  - err_code constants.
  - state enum.
  - op-class decode function: opcode -> {binary, unary_x, unary_y}.
- One natural sub-module, operand_stack: register file with sp, push, pop and replace ports, full/empty outputs, and tos/nos read ports.
- The sequencer FSM lives in the top module.

Test Plan:
- PUSH 5, PUSH 3, ALU ADD -> done in the WB cycle; tos=8, depth=1, flags=4'b0000; alu_x=5 and alu_y=3 during EXEC.
- PUSH 0x7FFF, PUSH 0x0001, ADD -> tos=0x8000; flags SF=1, OF=1, ZF=0.
- PUSH 0, ALU DCX -> tos=0xFFFF, depth=1, flags SF=1, ZF=0; NOTY then gives tos=0x0000, ZF=1.
- Reset, then ALU INX -> err with code 1; depth=0, flags=0. PUSH 1, then ADD -> err with code 1 and depth=1.
- 8 PUSHes (DEPTH=8), 9th PUSH -> err with code 2, depth=8, tos unchanged. CLEAR -> depth=0, tos=0, done.
- Start ADD, assert rst_n=0 during EXEC -> outputs return to reset values immediately; after release cmd_ready=1, depth=0.
